ifu_fetch: RTL and testbench

Instruction fetch unit for the RV32E core. It sits directly upstream of the decode stage.
- Holds the PC and issues word reads to instruction memory over a valid/ready request channel.
- Captures the returned 32-bit instruction and presents it with its PC to decode over a valid/ready output channel.
- Accepts redirects (jumps/branches/traps) from execute and discards any stale in-flight fetch.

---
 rtl/ifu_fetch.sv | 137 +++++++++++++
 tb/tb_ifu_fetch.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit for the RV32E core, upstream of decode.
//
// Holds the PC, issues single-word reads to instruction memory (at most one
// outstanding), captures the returned word and hands it to decode together with
// its PC. Redirects from execute replace the PC and cause any stale in-flight
// response to be discarded.
//
// Ports:
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   redirect_valid, redirect_pc     PC change request from execute
//   imem_req_valid/ready/addr       fetch request channel to instruction memory
//   imem_rsp_valid, imem_rsp_data   one-cycle response pulse per accepted request
//   inst_valid/ready, inst, inst_pc instruction channel to decode
//   fetch_misalign                  misaligned-PC flag accompanying inst
//
// Build option IFU_MISALIGN_CHECK_EN: when defined, a PC with nonzero low bits
// issues no memory read and delivers a NOP flagged with fetch_misalign. When
// undefined, fetch_misalign is tied low and the low PC bits are masked on the
// request address only.

module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            fetch_misalign
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic            drop;  // response of the outstanding request is stale
  logic            req_hs;

`ifdef IFU_MISALIGN_CHECK_EN
  localparam logic [XLEN-1:0] NopInst = 32'h0000_0013;

  logic misalign_q;
  logic misaligned;

  assign misaligned     = (pc[1:0] != 2'b00);
  assign imem_req_valid = (state == S_REQ) && !misaligned;
  assign imem_req_addr  = pc;
  assign fetch_misalign = misalign_q;
`else
  assign imem_req_valid = (state == S_REQ);
  assign imem_req_addr  = {pc[XLEN-1:2], 2'b00};
  assign fetch_misalign = 1'b0;
`endif

  assign inst_valid = (state == S_OUT);
  assign req_hs     = imem_req_valid && imem_req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      drop    <= 1'b0;
      inst    <= '0;
      inst_pc <= '0;
`ifdef IFU_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: state <= S_REQ;

        S_REQ: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
            // A request accepted this cycle went to the old PC.
            if (req_hs) begin
              drop  <= 1'b1;
              state <= S_WAIT;
            end
`ifdef IFU_MISALIGN_CHECK_EN
          end else if (misaligned) begin
            inst       <= NopInst;
            inst_pc    <= pc;
            misalign_q <= 1'b1;
            state      <= S_OUT;
`endif
          end else if (req_hs) begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (imem_rsp_valid) begin
            drop <= 1'b0;
            if (redirect_valid) begin
              pc    <= redirect_pc;
              state <= S_REQ;
            end else if (drop) begin
              state <= S_REQ;
            end else begin
              inst    <= imem_rsp_data;
              inst_pc <= pc;
`ifdef IFU_MISALIGN_CHECK_EN
              misalign_q <= 1'b0;
`endif
              state   <= S_OUT;
            end
          end else if (redirect_valid) begin
            pc   <= redirect_pc;
            drop <= 1'b1;
          end
        end

        S_OUT: begin
          // Redirect wins over the sequential PC even when decode consumes.
          if (redirect_valid) begin
            pc    <= redirect_pc;
            state <= S_REQ;
          end else if (inst_ready) begin
            pc    <= pc + 4;
            state <= S_REQ;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed stimulus with a scoreboard queue of expected
// instructions, checked by a monitor on every decode handshake, plus direct
// checks of request-side and reset behaviour.

module tb_ifu_fetch;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_misalign;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  logic mem_en = 1'b1;

  ifu_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .fetch_misalign (fetch_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_inst(input int max);
    int n;
    n = 0;
    while (!inst_valid && n < max) begin
      tick();
      n++;
    end
    if (!inst_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_inst_valid: no inst_valid within %0d cycles, required 1", max);
    end
  endtask

  // Memory model: data = addr ^ 32'h0F0F_0000, one-cycle response after an
  // accepted request. When mem_en is low the main process drives the response.
  initial begin
    logic        hs;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      hs = imem_req_valid && imem_req_ready;
      a  = imem_req_addr;
      @(posedge clk);
      #1;
      if (mem_en) begin
        imem_rsp_valid = hs;
        imem_rsp_data  = a ^ 32'h0F0F_0000;
      end
    end
  end

  // Monitor: a decode handshake happens at the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && inst_valid && inst_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got inst %h pc %h, required no instruction", inst, inst_pc);
        end else begin
          e = q.pop_front();
          check("sb_inst", inst, e.inst);
          check("sb_pc", inst_pc, e.pc);
          check("sb_misalign", {31'b0, fetch_misalign}, {31'b0, e.mis});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    inst_ready     = 1'b1;
    rst_n          = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_misalign", {31'b0, fetch_misalign}, 32'd0);
    check("rst_addr", imem_req_addr, 32'h8000_0000);

    q.push_back('{inst: 32'h8F0F_0000, pc: 32'h8000_0000, mis: 1'b0});
    q.push_back('{inst: 32'h8F0F_0004, pc: 32'h8000_0004, mis: 1'b0});
    rst_n = 1'b1;

    tick();  // IDLE -> REQ
    check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("first_req_addr", imem_req_addr, 32'h8000_0000);
    check("first_inst_valid", {31'b0, inst_valid}, 32'd0);
    tick();  // REQ -> WAIT
    check("wait_req_valid", {31'b0, imem_req_valid}, 32'd0);
    tick();  // WAIT -> OUT
    check("first_out_valid", {31'b0, inst_valid}, 32'd1);
    check("first_out_pc", inst_pc, 32'h8000_0000);
    check("first_out_inst", inst, 32'h8F0F_0000);
    repeat (3) tick();
    check("second_out_valid", {31'b0, inst_valid}, 32'd1);
    check("second_out_pc_3cyc", inst_pc, 32'h8000_0004);

    // Decode stall.
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", {31'b0, inst_valid}, 32'd1);
      check("stall_inst", inst, 32'h8F0F_0004);
      check("stall_pc", inst_pc, 32'h8000_0004);
      check("stall_no_req", {31'b0, imem_req_valid}, 32'd0);
    end
    q.push_back('{inst: 32'h8F0F_0008, pc: 32'h8000_0008, mis: 1'b0});
    inst_ready = 1'b1;
    tick();
    check("post_stall_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("post_stall_addr", imem_req_addr, 32'h8000_0008);
    tick();
    tick();
    check("third_out_pc", inst_pc, 32'h8000_0008);

    // Redirect coincident with decode handshake.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    tick();
    redirect_valid = 1'b0;
    mem_en         = 1'b0;
    check("redir_hs_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("redir_hs_addr", imem_req_addr, 32'h8000_0200);

    // Redirect while waiting; the stale response arrives two cycles later.
    tick();  // REQ -> WAIT
    check("redir_wait_state", {31'b0, imem_req_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    check("wait_after_redir_req", {31'b0, imem_req_valid}, 32'd0);
    check("wait_after_redir_inst", {31'b0, inst_valid}, 32'd0);
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    mem_en         = 1'b1;
    check("drop_no_inst", {31'b0, inst_valid}, 32'd0);
    check("drop_refetch_valid", {31'b0, imem_req_valid}, 32'd1);
    check("drop_refetch_addr", imem_req_addr, 32'h8000_0100);
    q.push_back('{inst: 32'h8F0F_0100, pc: 32'h8000_0100, mis: 1'b0});
    wait_inst(6);
    check("redir_target_pc", inst_pc, 32'h8000_0100);

    // Memory back-pressure, then asynchronous reset in the middle of it.
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_req_valid", {31'b0, imem_req_valid}, 32'd1);
      check("bp_req_addr", imem_req_addr, 32'h8000_0104);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("async_rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("async_rst_inst", inst, 32'd0);
    check("async_rst_inst_pc", inst_pc, 32'd0);
    check("async_rst_addr", imem_req_addr, 32'h8000_0000);
    tick();
    rst_n          = 1'b1;
    imem_req_ready = 1'b1;
    q.push_back('{inst: 32'h8F0F_0000, pc: 32'h8000_0000, mis: 1'b0});
    wait_inst(6);
    check("post_rst_pc", inst_pc, 32'h8000_0000);

    // Redirect to a misaligned target.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    tick();
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
    check("misalign_no_req", {31'b0, imem_req_valid}, 32'd0);
    tick();
    check("misalign_valid", {31'b0, inst_valid}, 32'd1);
    check("misalign_inst", inst, 32'h0000_0013);
    check("misalign_pc", inst_pc, 32'h8000_0102);
    check("misalign_flag", {31'b0, fetch_misalign}, 32'd1);
    check("misalign_still_no_req", {31'b0, imem_req_valid}, 32'd0);
`else
    check("unaligned_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("unaligned_addr_masked", imem_req_addr, 32'h8000_0100);
    wait_inst(6);
    check("unaligned_inst", inst, 32'h8F0F_0100);
    check("unaligned_inst_pc", inst_pc, 32'h8000_0102);
    check("unaligned_flag", {31'b0, fetch_misalign}, 32'd0);
`endif

    tick();
    check("sb_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
